// File: rtl/iommu_pkg.sv
// Shared types and constants for the IOMMU hardware performance monitor.
package iommu_pkg;

  typedef struct packed {
    logic [14:0] eventid;
    logic        dmask;
    logic [19:0] pid_pscid;
    logic [23:0] did_gscid;
    logic        pv_pscv;
    logic        dv_gscv;
    logic        idt;
  } hpm_evt_cfg_t;

  localparam logic [2:0] HPM_F_PID         = 3'b001;
  localparam logic [2:0] HPM_F_DID         = 3'b010;
  localparam logic [2:0] HPM_F_DID_PID     = 3'b011;
  localparam logic [2:0] HPM_F_PSCID       = 3'b101;
  localparam logic [2:0] HPM_F_GSCID       = 3'b110;
  localparam logic [2:0] HPM_F_GSCID_PSCID = 3'b111;

  localparam logic [14:0] EVT_NONE = 15'd0;

  // Selects the bits strictly above the lowest zero of pat; an all-ones pattern selects nothing.
  function automatic logic [23:0] hpm_upper_mask(input logic [23:0] pat);
    return ~(pat ^ (pat + 24'd1));
  endfunction

endpackage

// File: rtl/iommu_hpm_idmatch.sv
// Per-counter ID filter: decides whether the current ID tags satisfy one counter's filter config.
module iommu_hpm_idmatch
  import iommu_pkg::*;
(
  input  hpm_evt_cfg_t cfg,
  input  logic [23:0]  did,
  input  logic         did_v,
  input  logic [19:0]  pid,
  input  logic         pid_v,
  input  logic [19:0]  pscid,
  input  logic         pscid_v,
  input  logic [15:0]  gscid,
  input  logic         gscid_v,
  output logic         match
);

  logic [2:0]  mode;
  logic [23:0] did_mask;
  logic [23:0] gscid_mask;
  logic        did_ok;
  logic        pid_ok;
  logic        pscid_ok;
  logic        gscid_ok;
  logic        unused_eventid;

  assign unused_eventid = ^cfg.eventid;

  // Unknown tags count as matched, except a pid filter which needs a known pid.
  always_comb begin
    mode       = {cfg.idt, cfg.dv_gscv, cfg.pv_pscv};
    did_mask   = cfg.dmask ? hpm_upper_mask(cfg.did_gscid) : '1;
    gscid_mask = cfg.dmask ? hpm_upper_mask({8'hFF, cfg.did_gscid[15:0]}) : '1;
    did_ok     = !did_v || (((did ^ cfg.did_gscid) & did_mask) == '0);
    gscid_ok   = !gscid_v ||
                 ((({8'h00, gscid} ^ {8'h00, cfg.did_gscid[15:0]}) & gscid_mask) == '0);
    pid_ok     = pid_v && (pid == cfg.pid_pscid);
    pscid_ok   = !pscid_v || (pscid == cfg.pid_pscid);
    match      = 1'b1;
    case (mode)
      HPM_F_PID:         match = pid_ok;
      HPM_F_DID:         match = did_ok;
      HPM_F_DID_PID:     match = did_ok && pid_ok;
      HPM_F_PSCID:       match = pscid_ok;
      HPM_F_GSCID:       match = gscid_ok;
      HPM_F_GSCID_PSCID: match = gscid_ok && pscid_ok;
      default:           match = 1'b1;
    endcase
  end

endmodule

// File: rtl/iommu_hpm_ext.sv
// IOMMU performance monitor: internal cycle/event counters, optional input filter stage,
// overflow flags and a level interrupt cleared by a write-1 pulse.
module iommu_hpm_ext
  import iommu_pkg::*;
#(
  parameter int N_IOHPMCTR   = 8,
  parameter int CTR_W        = 64,
  parameter int N_EVT        = 16,
  parameter int FILTER_STAGE = 1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [N_EVT-1:0]                   evt_i,
  input  logic [23:0]                        did_i,
  input  logic                               did_v_i,
  input  logic [19:0]                        pid_i,
  input  logic                               pid_v_i,
  input  logic [19:0]                        pscid_i,
  input  logic                               pscid_v_i,
  input  logic [15:0]                        gscid_i,
  input  logic                               gscid_v_i,
  input  hpm_evt_cfg_t [N_IOHPMCTR-1:0]      evt_cfg_i,
  input  logic [N_IOHPMCTR:0]                countinh_i,
  input  logic [N_IOHPMCTR:0]                ctr_we_i,
  input  logic [CTR_W-1:0]                   ctr_wdata_i,
  input  logic [N_IOHPMCTR:0]                of_we_i,
  input  logic [N_IOHPMCTR:0]                of_wdata_i,
  input  logic                               ip_clr_i,
  output logic [N_IOHPMCTR:0][CTR_W-1:0]     ctr_o,
  output logic [N_IOHPMCTR:0]                of_o,
  output logic                               hpm_ip_o
);

  logic [N_EVT-1:0] evt_s;
  logic [23:0]      did_s;
  logic             did_v_s;
  logic [19:0]      pid_s;
  logic             pid_v_s;
  logic [19:0]      pscid_s;
  logic             pscid_v_s;
  logic [15:0]      gscid_s;
  logic             gscid_v_s;

  logic [CTR_W-2:0]                 cyc_q;
  logic [N_IOHPMCTR:1][CTR_W-1:0]   ctr_q;
  logic [N_IOHPMCTR:0]              of_q;
  logic                             ip_q;
  logic [N_IOHPMCTR:0]              inc;
  logic [N_IOHPMCTR:0]              wrap;
  logic                             ip_set;

  // Events and their tags travel together through the stage so filtering sees a consistent bundle.
  if (FILTER_STAGE != 0) begin : g_filter_reg
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        evt_s     <= '0;
        did_s     <= '0;
        did_v_s   <= 1'b0;
        pid_s     <= '0;
        pid_v_s   <= 1'b0;
        pscid_s   <= '0;
        pscid_v_s <= 1'b0;
        gscid_s   <= '0;
        gscid_v_s <= 1'b0;
      end else begin
        evt_s     <= evt_i;
        did_s     <= did_i;
        did_v_s   <= did_v_i;
        pid_s     <= pid_i;
        pid_v_s   <= pid_v_i;
        pscid_s   <= pscid_i;
        pscid_v_s <= pscid_v_i;
        gscid_s   <= gscid_i;
        gscid_v_s <= gscid_v_i;
      end
    end
  end else begin : g_filter_comb
    assign evt_s     = evt_i;
    assign did_s     = did_i;
    assign did_v_s   = did_v_i;
    assign pid_s     = pid_i;
    assign pid_v_s   = pid_v_i;
    assign pscid_s   = pscid_i;
    assign pscid_v_s = pscid_v_i;
    assign gscid_s   = gscid_i;
    assign gscid_v_s = gscid_v_i;
  end

  assign inc[0] = ~countinh_i[0];

  for (genvar g = 1; g <= N_IOHPMCTR; g++) begin : g_ctr
    logic hit;
    logic match;

    iommu_hpm_idmatch u_idmatch (
      .cfg     (evt_cfg_i[g-1]),
      .did     (did_s),
      .did_v   (did_v_s),
      .pid     (pid_s),
      .pid_v   (pid_v_s),
      .pscid   (pscid_s),
      .pscid_v (pscid_v_s),
      .gscid   (gscid_s),
      .gscid_v (gscid_v_s),
      .match   (match)
    );

    // Event ids outside 1..N_EVT select nothing and never count.
    always_comb begin
      hit = 1'b0;
      for (int e = 0; e < N_EVT; e++) begin
        if (evt_cfg_i[g-1].eventid != EVT_NONE && evt_cfg_i[g-1].eventid == 15'(e + 1)) begin
          hit = evt_s[e];
        end
      end
    end

    assign inc[g] = hit & match & ~countinh_i[g];
  end

  // A software counter write swallows a same-cycle increment, so it can never wrap.
  always_comb begin
    wrap[0] = inc[0] & ~ctr_we_i[0] & (&cyc_q);
    for (int i = 1; i <= N_IOHPMCTR; i++) begin
      wrap[i] = inc[i] & ~ctr_we_i[i] & (&ctr_q[i]);
    end
    ip_set = |(wrap & ~of_we_i & ~of_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_q <= '0;
      ctr_q <= '0;
      of_q  <= '0;
      ip_q  <= 1'b0;
    end else begin
      if (ctr_we_i[0]) begin
        cyc_q <= ctr_wdata_i[CTR_W-2:0];
      end else if (inc[0]) begin
        cyc_q <= cyc_q + (CTR_W-1)'(1'b1);
      end
      for (int i = 1; i <= N_IOHPMCTR; i++) begin
        if (ctr_we_i[i]) begin
          ctr_q[i] <= ctr_wdata_i;
        end else if (inc[i]) begin
          ctr_q[i] <= ctr_q[i] + CTR_W'(1'b1);
        end
      end
      for (int i = 0; i <= N_IOHPMCTR; i++) begin
        if (of_we_i[i]) begin
          of_q[i] <= of_wdata_i[i];
        end else if (wrap[i]) begin
          of_q[i] <= 1'b1;
        end
      end
      if (ip_set) begin
        ip_q <= 1'b1;
      end else if (ip_clr_i) begin
        ip_q <= 1'b0;
      end
    end
  end

  assign ctr_o    = {ctr_q, {1'b0, cyc_q}};
  assign of_o     = of_q;
  assign hpm_ip_o = ip_q;

endmodule

// File: tb/tb_iommu_hpm_ext.sv
// Bench for iommu_hpm_ext: directed scenarios followed by randomized traffic,
// all compared against a cycle-level behavioural model of the monitor.
module tb_iommu_hpm_ext;
  import iommu_pkg::*;

  localparam int N  = 8;
  localparam int W  = 64;
  localparam int NE = 16;
  localparam longint unsigned CYC_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam longint unsigned EVT_MAX = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [NE-1:0]         evt;
  logic [23:0]           did;
  logic                  did_v;
  logic [19:0]           pid;
  logic                  pid_v;
  logic [19:0]           pscid;
  logic                  pscid_v;
  logic [15:0]           gscid;
  logic                  gscid_v;
  hpm_evt_cfg_t [N-1:0]  cfg;
  logic [N:0]            inh;
  logic [N:0]            ctr_we;
  logic [W-1:0]          wdata;
  logic [N:0]            of_we;
  logic [N:0]            of_wdata;
  logic                  ip_clr;
  logic [N:0][W-1:0]     ctr;
  logic [N:0]            of;
  logic                  ip;

  iommu_hpm_ext #(
    .N_IOHPMCTR   (N),
    .CTR_W        (W),
    .N_EVT        (NE),
    .FILTER_STAGE (1)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .evt_i       (evt),
    .did_i       (did),
    .did_v_i     (did_v),
    .pid_i       (pid),
    .pid_v_i     (pid_v),
    .pscid_i     (pscid),
    .pscid_v_i   (pscid_v),
    .gscid_i     (gscid),
    .gscid_v_i   (gscid_v),
    .evt_cfg_i   (cfg),
    .countinh_i  (inh),
    .ctr_we_i    (ctr_we),
    .ctr_wdata_i (wdata),
    .of_we_i     (of_we),
    .of_wdata_i  (of_wdata),
    .ip_clr_i    (ip_clr),
    .ctr_o       (ctr),
    .of_o        (of),
    .hpm_ip_o    (ip)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: counters, flags, interrupt and the one-cycle-old input bundle.
  longint unsigned m_ctr [N+1];
  bit              m_of  [N+1];
  bit              m_ip;
  logic [NE-1:0]   p_evt;
  logic [23:0]     p_did;
  bit              p_did_v;
  logic [19:0]     p_pid;
  bit              p_pid_v;
  logic [19:0]     p_pscid;
  bit              p_pscid_v;
  logic [15:0]     p_gscid;
  bit              p_gscid_v;

  // Equality above the lowest zero of pat when dm is set, full equality otherwise.
  function automatic bit id_eq(longint unsigned a, longint unsigned pat, int width, bit dm);
    int lo;
    bit found;
    lo = 0;
    found = 1'b0;
    if (dm) begin
      lo = width;
      for (int k = 0; k < width; k++) begin
        if (!found && ((pat >> k) & 64'd1) == 64'd0) begin
          lo = k + 1;
          found = 1'b1;
        end
      end
    end
    return (a >> lo) == (pat >> lo);
  endfunction

  function automatic bit model_match(hpm_evt_cfg_t c);
    bit d_ok, g_ok, p_ok, s_ok;
    d_ok = !p_did_v || id_eq(64'(p_did), 64'(c.did_gscid), 24, c.dmask);
    g_ok = !p_gscid_v || id_eq(64'(p_gscid), 64'(c.did_gscid[15:0]), 16, c.dmask);
    p_ok = p_pid_v && (p_pid == c.pid_pscid);
    s_ok = !p_pscid_v || (p_pscid == c.pid_pscid);
    case ({c.idt, c.dv_gscv, c.pv_pscv})
      3'b001:  return p_ok;
      3'b010:  return d_ok;
      3'b011:  return d_ok && p_ok;
      3'b101:  return s_ok;
      3'b110:  return g_ok;
      3'b111:  return g_ok && s_ok;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i <= N; i++) begin
      m_ctr[i] = 0;
      m_of[i]  = 1'b0;
    end
    m_ip = 1'b0;
    p_evt = '0; p_did = '0; p_did_v = 1'b0; p_pid = '0; p_pid_v = 1'b0;
    p_pscid = '0; p_pscid_v = 1'b0; p_gscid = '0; p_gscid_v = 1'b0;
  endtask

  task automatic model_step();
    bit ip_set;
    ip_set = 1'b0;
    for (int i = 0; i <= N; i++) begin
      longint unsigned lim;
      bit inc, wrapped;
      int e;
      lim = (i == 0) ? CYC_MAX : EVT_MAX;
      wrapped = 1'b0;
      if (i == 0) begin
        inc = !inh[0];
      end else begin
        e = int'(cfg[i-1].eventid);
        inc = (e >= 1) && (e <= NE) && p_evt[e-1] && model_match(cfg[i-1]) && !inh[i];
      end
      if (ctr_we[i]) begin
        m_ctr[i] = 64'(wdata) & lim;
      end else if (inc) begin
        if (m_ctr[i] == lim) begin
          m_ctr[i] = 0;
          wrapped = 1'b1;
        end else begin
          m_ctr[i] = m_ctr[i] + 1;
        end
      end
      if (of_we[i]) begin
        m_of[i] = of_wdata[i];
      end else if (wrapped) begin
        if (!m_of[i]) ip_set = 1'b1;
        m_of[i] = 1'b1;
      end
    end
    if (ip_set) m_ip = 1'b1;
    else if (ip_clr) m_ip = 1'b0;
    p_evt = evt; p_did = did; p_did_v = did_v; p_pid = pid; p_pid_v = pid_v;
    p_pscid = pscid; p_pscid_v = pscid_v; p_gscid = gscid; p_gscid_v = gscid_v;
  endtask

  // One clock: the model consumes the inputs seen at the edge, then strobes drop.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    #1;
    evt = '0;
    ctr_we = '0;
    of_we = '0;
    ip_clr = 1'b0;
  endtask

  task automatic check_output(string tag, logic [63:0] observed, logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_model(string tag);
    for (int i = 0; i <= N; i++) begin
      check_output($sformatf("%s ctr[%0d]", tag, i), ctr[i], m_ctr[i]);
      check_output($sformatf("%s of[%0d]", tag, i), 64'(of[i]), 64'(m_of[i]));
    end
    check_output({tag, " ip"}, 64'(ip), 64'(m_ip));
  endtask

  task automatic apply_stimulus();
    int idx;
    evt = NE'($urandom);
    case ($urandom_range(0, 3))
      0:       did = 24'h123400;
      1:       did = 24'h1234C5;
      2:       did = 24'h123500;
      default: did = 24'($urandom);
    endcase
    did_v   = ($urandom_range(0, 4) != 0);
    pid     = ($urandom_range(0, 1) != 0) ? 20'h00ABC : 20'($urandom);
    pid_v   = ($urandom_range(0, 4) != 0);
    pscid   = ($urandom_range(0, 1) != 0) ? 20'h00055 : 20'($urandom);
    pscid_v = ($urandom_range(0, 4) != 0);
    case ($urandom_range(0, 3))
      0:       gscid = 16'h0077;
      1:       gscid = 16'h0070;
      2:       gscid = 16'h0170;
      default: gscid = 16'($urandom);
    endcase
    gscid_v = ($urandom_range(0, 4) != 0);
    inh     = ($urandom_range(0, 5) == 0) ? (N+1)'($urandom) : '0;
    if ($urandom_range(0, 7) == 0) begin
      idx = $urandom_range(0, N);
      ctr_we[idx] = 1'b1;
      wdata = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 2));
    end
    if ($urandom_range(0, 11) == 0) begin
      idx = $urandom_range(0, N);
      of_we[idx] = 1'b1;
      of_wdata = (N+1)'($urandom);
    end
    ip_clr = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    evt = '0; did = '0; did_v = 1'b0; pid = '0; pid_v = 1'b0;
    pscid = '0; pscid_v = 1'b0; gscid = '0; gscid_v = 1'b0;
    cfg = '0; inh = '0; ctr_we = '0; wdata = '0; of_we = '0; of_wdata = '0; ip_clr = 1'b0;
    model_reset();
    tick();
    tick();

    for (int i = 0; i <= N; i++) begin
      check_output($sformatf("reset ctr[%0d]", i), ctr[i], 64'd0);
    end
    check_output("reset of", 64'(of), 64'd0);
    check_output("reset ip", 64'(ip), 64'd0);

    // Cycles counter runs freely, event counters idle.
    rst_n = 1'b1;
    repeat (10) tick();
    check_output("t1 cycles", ctr[0], 64'd10);
    for (int i = 1; i <= N; i++) begin
      check_output($sformatf("t1 ctr[%0d]", i), ctr[i], 64'd0);
    end
    check_output("t1 ip", 64'(ip), 64'd0);
    check_model("t1");

    // Two-edge latency through the filter stage.
    cfg[0].eventid = 15'd3;
    evt[2] = 1'b1;
    tick();
    check_output("t2 before", ctr[1], 64'd0);
    tick();
    check_output("t2 after", ctr[1], 64'd1);
    check_model("t2");

    // Partial DID match above the lowest zero of 0x12347F.
    cfg[1].eventid   = 15'd4;
    cfg[1].dv_gscv   = 1'b1;
    cfg[1].dmask     = 1'b1;
    cfg[1].did_gscid = 24'h12347F;
    did_v = 1'b1; did = 24'h123400; evt[3] = 1'b1;
    tick(); tick();
    check_output("t3 did match", ctr[2], 64'd1);
    did = 24'h123500; evt[3] = 1'b1;
    tick(); tick();
    check_output("t3 did miss", ctr[2], 64'd1);
    did_v = 1'b0; evt[3] = 1'b1;
    tick(); tick();
    check_output("t3 did unknown", ctr[2], 64'd2);
    check_model("t3");

    // Wrap raises OF and interrupt; a wrap with OF already set does not.
    cfg[2].eventid = 15'd5;
    ctr_we[3] = 1'b1; wdata = '1;
    tick();
    check_output("t4 written", ctr[3], 64'hFFFF_FFFF_FFFF_FFFF);
    evt[4] = 1'b1;
    tick(); tick();
    check_output("t4 wrap ctr", ctr[3], 64'd0);
    check_output("t4 wrap of", 64'(of[3]), 64'd1);
    check_output("t4 wrap ip", 64'(ip), 64'd1);
    ip_clr = 1'b1;
    tick();
    check_output("t4 ip cleared", 64'(ip), 64'd0);
    ctr_we[3] = 1'b1; wdata = '1; evt[4] = 1'b1;
    tick(); tick();
    check_output("t4 rewrap ctr", ctr[3], 64'd0);
    check_output("t4 rewrap of", 64'(of[3]), 64'd1);
    check_output("t4 rewrap ip", 64'(ip), 64'd0);
    check_model("t4");

    // Software write beats a same-edge increment.
    evt[2] = 1'b1;
    tick();
    ctr_we[1] = 1'b1; wdata = 64'h55;
    tick();
    check_output("t5 write wins", ctr[1], 64'h55);
    tick();
    check_output("t5 held", ctr[1], 64'h55);
    check_model("t5");

    // Interrupt set beats clear; OF writes never touch the interrupt.
    of_we[3] = 1'b1; of_wdata[3] = 1'b0;
    tick();
    check_output("t6 of cleared", 64'(of[3]), 64'd0);
    ctr_we[3] = 1'b1; wdata = '1; evt[4] = 1'b1;
    tick();
    ip_clr = 1'b1;
    tick();
    check_output("t6 set beats clr", 64'(ip), 64'd1);
    check_output("t6 of set", 64'(of[3]), 64'd1);
    check_output("t6 ctr wrapped", ctr[3], 64'd0);
    of_we[3] = 1'b1; of_wdata[3] = 1'b1;
    tick();
    check_output("t6 of write ip", 64'(ip), 64'd1);
    ip_clr = 1'b1; of_we[3] = 1'b1; of_wdata[3] = 1'b0;
    ctr_we[3] = 1'b1; wdata = '1; evt[4] = 1'b1;
    tick();
    check_output("t6 prep ip", 64'(ip), 64'd0);
    of_we[3] = 1'b1; of_wdata[3] = 1'b0;
    tick();
    check_output("t6 of write beats hw ctr", ctr[3], 64'd0);
    check_output("t6 of write beats hw of", 64'(of[3]), 64'd0);
    check_output("t6 of write beats hw ip", 64'(ip), 64'd0);
    check_model("t6");

    // Asynchronous reset drops everything, including an event held in the stage.
    evt[2] = 1'b1;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check_output("t7 async ctr0", ctr[0], 64'd0);
    check_output("t7 async ctr1", ctr[1], 64'd0);
    check_output("t7 async ctr3", ctr[3], 64'd0);
    check_output("t7 async of", 64'(of), 64'd0);
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();
    check_output("t7 no stale event", ctr[1], 64'd0);
    check_output("t7 cycles restart", ctr[0], 64'd1);
    check_model("t7");

    // Randomized traffic across every filter mode.
    cfg = '0;
    cfg[0].eventid = 15'd1;  cfg[0].idt = 1'b1;
    cfg[1].eventid = 15'd2;  cfg[1].pv_pscv = 1'b1; cfg[1].pid_pscid = 20'h00ABC;
    cfg[2].eventid = 15'd3;  cfg[2].dv_gscv = 1'b1; cfg[2].dmask = 1'b1;
    cfg[2].did_gscid = 24'h12347F;
    cfg[3].eventid = 15'd4;  cfg[3].dv_gscv = 1'b1; cfg[3].pv_pscv = 1'b1;
    cfg[3].did_gscid = 24'h123400; cfg[3].pid_pscid = 20'h00ABC;
    cfg[4].eventid = 15'd5;  cfg[4].idt = 1'b1; cfg[4].pv_pscv = 1'b1;
    cfg[4].pid_pscid = 20'h00055;
    cfg[5].eventid = 15'd6;  cfg[5].idt = 1'b1; cfg[5].dv_gscv = 1'b1;
    cfg[5].dmask = 1'b1; cfg[5].did_gscid = 24'h000077;
    cfg[6].eventid = 15'd16; cfg[6].idt = 1'b1; cfg[6].dv_gscv = 1'b1; cfg[6].pv_pscv = 1'b1;
    cfg[6].did_gscid = 24'h000077; cfg[6].pid_pscid = 20'h00055;
    cfg[7].eventid = 15'd17;
    repeat (400) begin
      apply_stimulus();
      tick();
      check_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
